sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Arbitrates a CPU port (read/write) and a program-loader port (write-only)
//   onto one asynchronous 16-bit SRAM. Each transfer walks
//   IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
//   All SRAM controls, the ready pulses, busy and cpu_rdata are registered.
//   The next-cycle values are decoded from the next state so every output
//   is valid for the whole cycle of the state it belongs to.
//
// Configuration macro:
//   SRAM_ARB_RR_EN  defined   : round-robin. A simultaneous request goes to
//                               the requester that did not own the last grant.
//                   undefined : fixed priority. The loader always wins.
//
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   cpu_req/cpu_we         CPU level request, 1 = write
//   cpu_addr/cpu_wdata     CPU word address / write data
//   cpu_rdata/cpu_ready    read data (held until next CPU read) / done pulse
//   ld_req/ld_addr/ld_wdata loader write request, address, data
//   ld_ready               loader done pulse
//   CE, UB, LB, OE, WE     active-low SRAM controls
//   ADDR, Data             SRAM address / shared bidirectional data bus
//   busy, owner            not-IDLE flag / 0 = CPU, 1 = loader
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        ld_req,
  input  logic [19:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic        ld_ready,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter value in the final ACCESS cycle.
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

  state_t      state_r, state_nx_s;
  logic [2:0]  cnt_r, cnt_nx_s;
  logic        grant_ld_s;
  logic        start_s;
  logic        wr_r, wr_nx_s;
  logic [19:0] addr_r;
  logic [15:0] wdata_r;
  logic        owner_r;
  logic        drive_r;
  logic        ce_nx_s, oe_nx_s, we_nx_s, drive_nx_s;

  assign ADDR  = addr_r;
  assign owner = owner_r;
  // Only the ACCESS and DONE cycles of a write put data on the bus.
  assign Data  = drive_r ? wdata_r : 16'hzzzz;

  // Arbitration between the two requesters, evaluated only when IDLE.
  always_comb begin
    grant_ld_s = 1'b0;
    start_s    = 1'b0;
    if (state_r == IDLE) begin
      start_s = cpu_req | ld_req;
      if (ld_req && cpu_req) begin
`ifdef SRAM_ARB_RR_EN
        grant_ld_s = ~owner_r;
`else
        grant_ld_s = 1'b1;
`endif
      end else begin
        grant_ld_s = ld_req;
      end
    end else begin
      start_s    = 1'b0;
      grant_ld_s = 1'b0;
    end
  end

  // Next state and ACCESS wait counter.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_nx_s = 3'd0;
        if (start_s) begin
          state_nx_s = SETUP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SETUP: begin
        state_nx_s = ACCESS;
        cnt_nx_s   = 3'd0;
      end
      ACCESS: begin
        if (cnt_r == LAST_CNT) begin
          state_nx_s = DONE;
          cnt_nx_s   = 3'd0;
        end else begin
          state_nx_s = ACCESS;
          cnt_nx_s   = cnt_r + 3'd1;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 3'd0;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 3'd0;
      end
    endcase
  end

  // SRAM control values for the state being entered. The direction must
  // come from the about-to-be-latched request when leaving IDLE.
  always_comb begin
    ce_nx_s    = 1'b1;
    oe_nx_s    = 1'b1;
    we_nx_s    = 1'b1;
    drive_nx_s = 1'b0;
    if (start_s) begin
      wr_nx_s = grant_ld_s | cpu_we;
    end else begin
      wr_nx_s = wr_r;
    end
    case (state_nx_s)
      IDLE: begin
        ce_nx_s = 1'b1;
      end
      SETUP: begin
        ce_nx_s = 1'b0;
        oe_nx_s = wr_nx_s;
      end
      ACCESS: begin
        ce_nx_s = 1'b0;
        if (wr_nx_s) begin
          we_nx_s    = 1'b0;
          drive_nx_s = 1'b1;
        end else begin
          oe_nx_s = 1'b0;
        end
      end
      DONE: begin
        // Writes keep the bus driven one more cycle for data hold time.
        ce_nx_s    = 1'b0;
        drive_nx_s = wr_nx_s;
      end
      default: begin
        ce_nx_s = 1'b1;
      end
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      cnt_r     <= 3'd0;
      wr_r      <= 1'b0;
      addr_r    <= 20'h00000;
      wdata_r   <= 16'h0000;
      owner_r   <= 1'b0;
      drive_r   <= 1'b0;
      CE        <= 1'b1;
      UB        <= 1'b1;
      LB        <= 1'b1;
      OE        <= 1'b1;
      WE        <= 1'b1;
      cpu_rdata <= 16'h0000;
      cpu_ready <= 1'b0;
      ld_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      wr_r    <= wr_nx_s;
      if (start_s) begin
        addr_r  <= grant_ld_s ? ld_addr : cpu_addr;
        wdata_r <= grant_ld_s ? ld_wdata : cpu_wdata;
        owner_r <= grant_ld_s;
      end
      drive_r <= drive_nx_s;
      CE      <= ce_nx_s;
      UB      <= ce_nx_s;
      LB      <= ce_nx_s;
      OE      <= oe_nx_s;
      WE      <= we_nx_s;
      // Read data is sampled while OE is still low, on the edge into DONE.
      if ((state_r == ACCESS) && (state_nx_s == DONE) && !wr_r && !owner_r) begin
        cpu_rdata <= Data;
      end
      cpu_ready <= (state_nx_s == DONE) && !owner_r;
      ld_ready  <= (state_nx_s == DONE) && owner_r;
      busy      <= (state_nx_s != IDLE);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter. Instance a uses WAIT_CYCLES=1 with a
// small SRAM model; instance b uses WAIT_CYCLES=3 for the loader test.
// Both data buses carry a pull-up so an undriven bus reads 16'hFFFF.
// Inputs change and outputs are checked on the falling clock edge.
module tb_sram_arbiter;

  logic clk;
  logic reset;

  logic        a_cpu_req, a_cpu_we, a_ld_req;
  logic [19:0] a_cpu_addr, a_ld_addr;
  logic [15:0] a_cpu_wdata, a_ld_wdata;
  logic [15:0] a_cpu_rdata;
  logic        a_cpu_ready, a_ld_ready;
  logic        a_ce, a_ub, a_lb, a_oe, a_we, a_busy, a_owner;
  logic [19:0] a_addr;
  tri   [15:0] a_data;

  logic        b_cpu_req, b_cpu_we, b_ld_req;
  logic [19:0] b_cpu_addr, b_ld_addr;
  logic [15:0] b_cpu_wdata, b_ld_wdata;
  logic [15:0] b_cpu_rdata;
  logic        b_cpu_ready, b_ld_ready;
  logic        b_ce, b_ub, b_lb, b_oe, b_we, b_busy, b_owner;
  logic [19:0] b_addr;
  tri   [15:0] b_data;

  int tests_run;
  int tests_failed;

  logic        sram_en;
  logic [15:0] mem [0:255];
  logic        exp_owner;

  pullup (a_data);
  pullup (b_data);

  sram_arbiter #(.WAIT_CYCLES(1)) dut_a (
    .Clk(clk), .Reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
    .ld_req(a_ld_req), .ld_addr(a_ld_addr), .ld_wdata(a_ld_wdata),
    .ld_ready(a_ld_ready),
    .CE(a_ce), .UB(a_ub), .LB(a_lb), .OE(a_oe), .WE(a_we),
    .ADDR(a_addr), .Data(a_data), .busy(a_busy), .owner(a_owner)
  );

  sram_arbiter #(.WAIT_CYCLES(3)) dut_b (
    .Clk(clk), .Reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
    .ld_req(b_ld_req), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata),
    .ld_ready(b_ld_ready),
    .CE(b_ce), .UB(b_ub), .LB(b_lb), .OE(b_oe), .WE(b_we),
    .ADDR(b_addr), .Data(b_data), .busy(b_busy), .owner(b_owner)
  );

  // SRAM model behind instance a: reads drive the bus while OE is low.
  assign a_data = (sram_en && !a_ce && !a_oe && a_we) ? mem[a_addr[7:0]] : 16'hzzzz;

  // SRAM model write port: stores the bus at the end of every WE-low cycle.
  always @(posedge clk) begin
    if (!a_ce && !a_we) begin
      mem[a_addr[7:0]] <= a_data;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sram_en      = 1'b1;
    reset        = 1'b1;
    a_cpu_req = 1'b0; a_cpu_we = 1'b0; a_cpu_addr = 20'h0; a_cpu_wdata = 16'h0;
    a_ld_req  = 1'b0; a_ld_addr = 20'h0; a_ld_wdata = 16'h0;
    b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 20'h0; b_cpu_wdata = 16'h0;
    b_ld_req  = 1'b0; b_ld_addr = 20'h0; b_ld_wdata = 16'h0;

    // ---------------- reset state ----------------
    step(); step();
    chk("rst_ce",    32'(a_ce), 32'h1);
    chk("rst_ub_lb", 32'({a_ub, a_lb}), 32'h3);
    chk("rst_oe_we", 32'({a_oe, a_we}), 32'h3);
    chk("rst_addr",  32'(a_addr), 32'h0);
    chk("rst_rdata", 32'(a_cpu_rdata), 32'h0);
    chk("rst_ready", 32'({a_cpu_ready, a_ld_ready}), 32'h0);
    chk("rst_busy",  32'(a_busy), 32'h0);
    chk("rst_owner", 32'(a_owner), 32'h0);
    chk("rst_data",  32'(a_data), 32'hFFFF);
    chk("rst_b_ctl", 32'({b_ce, b_oe, b_we, b_busy}), 32'hE);
    reset = 1'b0;
    step();

    // ---------------- CPU write 0x00010 / 0xBEEF (cycle n = IDLE) ----------------
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 20'h00010; a_cpu_wdata = 16'hBEEF;
    step(); // n+1 SETUP
    chk("wr_setup_ctl",  32'({a_ce, a_ub, a_lb, a_oe, a_we}), 32'h03);
    chk("wr_setup_addr", 32'(a_addr), 32'h00010);
    chk("wr_setup_data", 32'(a_data), 32'hFFFF);
    chk("wr_setup_busy", 32'({a_busy, a_owner}), 32'h2);
    // requester inputs move during the transfer; latched values must hold
    a_cpu_addr = 20'h55555; a_cpu_wdata = 16'h0000;
    step(); // n+2 ACCESS
    chk("wr_acc_we",    32'(a_we), 32'h0);
    chk("wr_acc_data",  32'(a_data), 32'hBEEF);
    chk("wr_acc_rdy",   32'(a_cpu_ready), 32'h0);
    chk("wr_acc_addr",  32'(a_addr), 32'h00010);
    step(); // n+3 DONE
    chk("wr_done_we",   32'(a_we), 32'h1);
    chk("wr_done_data", 32'(a_data), 32'hBEEF);
    chk("wr_done_rdy",  32'({a_cpu_ready, a_ld_ready}), 32'h2);
    chk("wr_done_addr", 32'(a_addr), 32'h00010);
    a_cpu_req = 1'b0;
    step(); // n+4 IDLE
    chk("wr_idle_rdy",  32'(a_cpu_ready), 32'h0);
    chk("wr_idle_ctl",  32'({a_ce, a_busy}), 32'h2);
    chk("wr_idle_data", 32'(a_data), 32'hFFFF);

    // ---------------- CPU read 0x00010 with SRAM model ----------------
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 20'h00010; a_cpu_wdata = 16'hA5A5;
    step(); // SETUP
    chk("rd_setup_ctl", 32'({a_ce, a_oe, a_we}), 32'h1);
    step(); // ACCESS
    chk("rd_acc_ctl",   32'({a_ce, a_oe, a_we}), 32'h1);
    chk("rd_acc_rdata", 32'(a_cpu_rdata), 32'h0);
    step(); // DONE
    chk("rd_done_rdata", 32'(a_cpu_rdata), 32'hBEEF);
    chk("rd_done_rdy",   32'({a_cpu_ready, a_ld_ready}), 32'h2);
    chk("rd_done_we",    32'(a_we), 32'h1);
    a_cpu_req = 1'b0;
    step(); // IDLE
    chk("rd_hold_rdata", 32'(a_cpu_rdata), 32'hBEEF);

    // ---------------- CPU read with SRAM silent: block must never drive ----------------
    sram_en = 1'b0;
    a_cpu_req = 1'b1;
    step(); chk("rdz_setup",  32'(a_data), 32'hFFFF);
    step(); chk("rdz_access", 32'(a_data), 32'hFFFF);
    step(); chk("rdz_done",   32'(a_data), 32'hFFFF);
    a_cpu_req = 1'b0;
    sram_en = 1'b1;
    step();
    chk("rdz_rdata", 32'(a_cpu_rdata), 32'hFFFF);

    // ---------------- both requesters held high ----------------
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 20'h00030; a_cpu_wdata = 16'h2222;
    a_ld_req  = 1'b1; a_ld_addr = 20'h00020; a_ld_wdata = 16'h1111;
    for (int g = 0; g < 4; g++) begin
`ifdef SRAM_ARB_RR_EN
      exp_owner = (g % 2 == 0) ? 1'b1 : 1'b0;
`else
      exp_owner = 1'b1;
`endif
      step(); // SETUP
      chk("arb_owner", 32'(a_owner), 32'(exp_owner));
      chk("arb_addr",  32'(a_addr), exp_owner ? 32'h00020 : 32'h00030);
      step(); // ACCESS
      step(); // DONE
      chk("arb_ready", 32'({a_cpu_ready, a_ld_ready}), exp_owner ? 32'h1 : 32'h2);
      step(); // IDLE
      chk("arb_idle_busy", 32'(a_busy), 32'h0);
    end
    a_cpu_req = 1'b0; a_ld_req = 1'b0;
    step();

    // ---------------- reset during ACCESS of a CPU write ----------------
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 20'h00040; a_cpu_wdata = 16'h7777;
    step(); // SETUP
    step(); // ACCESS
    chk("abort_acc_we", 32'(a_we), 32'h0);
    reset = 1'b1; a_cpu_req = 1'b0;
    step(); // reset applied at the edge
    chk("abort_ctl",   32'({a_ce, a_ub, a_lb, a_oe, a_we}), 32'h1F);
    chk("abort_data",  32'(a_data), 32'hFFFF);
    chk("abort_rdy",   32'({a_cpu_ready, a_ld_ready}), 32'h0);
    chk("abort_busy",  32'(a_busy), 32'h0);
    chk("abort_addr",  32'(a_addr), 32'h0);
    reset = 1'b0;
    step();
    chk("abort_after_rdy",  32'(a_cpu_ready), 32'h0);
    chk("abort_after_busy", 32'(a_busy), 32'h0);

    // ---------------- WAIT_CYCLES=3 loader write 0x3FFFF / 0x1234 ----------------
    b_ld_req = 1'b1; b_ld_addr = 20'h3FFFF; b_ld_wdata = 16'h1234; b_cpu_we = 1'b0;
    step(); // n+1 SETUP
    chk("ld_setup_we",   32'(b_we), 32'h1);
    chk("ld_setup_addr", 32'(b_addr), 32'h3FFFF);
    chk("ld_owner",      32'(b_owner), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step(); // n+2 .. n+4 ACCESS
      chk("ld_acc_we",   32'(b_we), 32'h0);
      chk("ld_acc_data", 32'(b_data), 32'h1234);
      chk("ld_acc_rdy",  32'(b_ld_ready), 32'h0);
    end
    step(); // n+5 DONE
    chk("ld_done_rdy",  32'({b_cpu_ready, b_ld_ready}), 32'h1);
    chk("ld_done_we",   32'(b_we), 32'h1);
    chk("ld_done_data", 32'(b_data), 32'h1234);
    b_ld_req = 1'b0;
    step();
    chk("ld_idle_rdy",  32'({b_cpu_ready, b_ld_ready}), 32'h0);
    chk("ld_idle_data", 32'(b_data), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
